// File: rtl/nco_pkg.sv
// Shared constants for the quadrature NCO: default widths, quadrant encoding,
// full-scale helper and phase-dither LFSR definition.
package nco_pkg;

    localparam int DEFAULT_PHASE_W = 32;
    localparam int DEFAULT_LUT_AW  = 6;
    localparam int DEFAULT_OUT_W   = 8;

    // Quadrant = top two phase bits; bit 0 mirrors the table, bit 1 negates it.
    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;
    localparam int QUAD_MIRROR_BIT = 0;
    localparam int QUAD_NEGATE_BIT = 1;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int full_scale(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine ROM with registered read. Holds 2^LUT_AW + 1 entries so the
// mirrored index 2^LUT_AW lands directly on full scale.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int LUT_AW = DEFAULT_LUT_AW,
    parameter int OUT_W  = DEFAULT_OUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW:0]   addr,
    output logic [OUT_W-1:0]  data
);

    localparam int  DEPTH   = (1 << LUT_AW) + 1;
    localparam real HALF_PI = 1.5707963267948966;

    function automatic int lut_entry(input int i);
        real angle;
        angle = HALF_PI * real'(i) / real'(1 << LUT_AW);
        return $rtoi(real'(full_scale(OUT_W)) * $sin(angle) + 0.5);
    endfunction

    logic [OUT_W-1:0] rom_mem [DEPTH];

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam int ENTRY = lut_entry(gi);
        assign rom_mem[gi] = OUT_W'(ENTRY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= rom_mem[addr];
        end
    end

endmodule

// File: rtl/nco_quad_pipe.sv
// Pipelined quadrature NCO: phase accumulator -> offset -> quarter-wave fold/LUT -> sign.
// Optional build macro NCO_PHASE_DITHER_EN adds LFSR dither below the LUT index.
module nco_quad_pipe
    import nco_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int LUT_AW  = DEFAULT_LUT_AW,
    parameter int OUT_W   = DEFAULT_OUT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] ctrl_in,
    input  logic               ctrl_load,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic               phase_sync,
    output logic [PHASE_W-1:0] phase,
    output logic [OUT_W-1:0]   sin_out,
    output logic [OUT_W-1:0]   cos_out,
    output logic               out_valid
);

    localparam int FRAC_W = PHASE_W - LUT_AW - 2;
    localparam logic [PHASE_W-1:0] QUARTER  = PHASE_W'(1) << (PHASE_W - 2);
    localparam logic [LUT_AW:0]    LUT_SPAN = {1'b1, {LUT_AW{1'b0}}};

    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] ctrl_active_reg;
    logic [PHASE_W-1:0] p_eff_next;
    logic [PHASE_W-1:0] eff_reg [2];   // [0] sine phase, [1] cosine phase
    logic               v1_reg;
    logic               v2_reg;
    logic [LUT_AW:0]    lut_addr [2];
    logic [OUT_W-1:0]   lut_data [2];
    logic [OUT_W-1:0]   out_next [2];
    logic               unused_frac;

    assign phase       = phase_reg;
    assign unused_frac = ^{eff_reg[0], eff_reg[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg       <= '0;
            ctrl_active_reg <= '0;
        end else begin
            if (phase_sync) begin
                phase_reg <= '0;
            end else if (enable) begin
                phase_reg <= phase_reg + ctrl_active_reg;
            end
            if (ctrl_load) begin
                ctrl_active_reg <= ctrl_in;
            end
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    logic [15:0]        lfsr_reg;
    logic [PHASE_W-1:0] dither;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else if (enable) begin
            lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    // Dither occupies only the truncated bits, so at most one index step of carry.
    if (FRAC_W >= 16) begin : g_dither_wide
        assign dither = PHASE_W'(lfsr_reg) << (FRAC_W - 16);
    end else if (FRAC_W > 0) begin : g_dither_narrow
        assign dither = PHASE_W'(lfsr_reg >> (16 - FRAC_W));
    end else begin : g_dither_none
        assign dither = '0;
    end

    assign p_eff_next = phase_reg + phase_offset + dither;
`else
    assign p_eff_next = phase_reg + phase_offset;
`endif

    // Stage 1: the pre-update phase is sampled, even alongside phase_sync.
    always_ff @(posedge clk) begin
        if (reset) begin
            eff_reg[0] <= '0;
            eff_reg[1] <= '0;
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
        end else begin
            v1_reg <= enable;
            v2_reg <= v1_reg;
            if (enable) begin
                eff_reg[0] <= p_eff_next;
                eff_reg[1] <= p_eff_next + QUARTER;
            end
        end
    end

    // Stage 2: quadrant fold and ROM read; sign travels alongside the ROM latency.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_path
        logic [1:0]        quad;
        logic [LUT_AW-1:0] k;
        logic              neg_reg;

        assign quad = eff_reg[gi][PHASE_W-1 -: 2];
        assign k    = eff_reg[gi][PHASE_W-3 -: LUT_AW];
        assign lut_addr[gi] = quad[QUAD_MIRROR_BIT] ? (LUT_SPAN - {1'b0, k}) : {1'b0, k};

        nco_quarter_lut #(
            .LUT_AW (LUT_AW),
            .OUT_W  (OUT_W)
        ) u_lut (
            .clk    (clk),
            .reset  (reset),
            .addr   (lut_addr[gi]),
            .data   (lut_data[gi])
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                neg_reg <= 1'b0;
            end else begin
                neg_reg <= quad[QUAD_NEGATE_BIT];
            end
        end

        assign out_next[gi] = neg_reg ? -lut_data[gi] : lut_data[gi];
    end

    // Stage 3: outputs only move when a sample exits, otherwise they hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2_reg;
            if (v2_reg) begin
                sin_out <= out_next[0];
                cos_out <= out_next[1];
            end
        end
    end

endmodule

// File: tb/tb_nco_quad_pipe.sv
// Scoreboard bench for nco_quad_pipe: a driver predicts samples with real-valued
// trigonometry and a monitor checks outputs, latency, holds and reset behaviour.
module tb_nco_quad_pipe;

    localparam real TWO_PI = 6.283185307179586;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] ctrl_in = '0;
    logic        ctrl_load = 1'b0;
    logic [31:0] phase_offset = '0;
    logic        phase_sync = 1'b0;
    logic [31:0] phase;
    logic [7:0]  sin_out;
    logic [7:0]  cos_out;
    logic        out_valid;

    nco_quad_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ctrl_in      (ctrl_in),
        .ctrl_load    (ctrl_load),
        .phase_offset (phase_offset),
        .phase_sync   (phase_sync),
        .phase        (phase),
        .sin_out      (sin_out),
        .cos_out      (cos_out),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s0;
        int c0;
        int s1;
        int c1;
        int due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic [31:0] m_phase = '0;
    logic [31:0] m_ctrl = '0;
    logic [31:0] exp_phase = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal 8-bit amplitude of a 256-point circle, rounded half away from zero.
    function automatic int amp(input int n, input bit is_cos);
        real a;
        real v;
        int  m;
        a = TWO_PI * real'(n % 256) / 256.0;
        v = is_cos ? $cos(a) : $sin(a);
        m = $rtoi(((v < 0.0) ? -v : v) * 127.0 + 0.5);
        return (v < 0.0) ? -m : m;
    endfunction

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic step(input bit en, input bit ld, input logic [31:0] cin,
                        input logic [31:0] off, input bit sy, input bit rst);
        logic [31:0] p;
        int          n;
        int          alt;
        exp_t        e;
        @(negedge clk);
        enable = en; ctrl_load = ld; ctrl_in = cin;
        phase_offset = off; phase_sync = sy; reset = rst;
        if (rst) begin
            sb.delete();
            m_phase = '0;
            m_ctrl  = '0;
        end else begin
            if (en) begin
                p = m_phase + off;
                n = int'(p >> 24);
`ifdef NCO_PHASE_DITHER_EN
                alt = (n + 1) % 256;
`else
                alt = n;
`endif
                e.s0 = amp(n, 1'b0);   e.c0 = amp(n, 1'b1);
                e.s1 = amp(alt, 1'b0); e.c1 = amp(alt, 1'b1);
                e.due = cyc + 3;
                sb.push_back(e);
            end
            if (sy) m_phase = '0;
            else if (en) m_phase = m_phase + m_ctrl;
            if (ld) m_ctrl = cin;
        end
        exp_phase = m_phase;
    endtask

    // Monitor: one line of checking per cycle, 1 time unit after the active edge.
    initial begin : monitor
        int   hold_s;
        int   hold_c;
        int   s;
        int   c;
        exp_t e;
        hold_s = 0;
        hold_c = 0;
        forever begin
            @(posedge clk);
            #1;
            s = int'($signed(sin_out));
            c = int'($signed(cos_out));
            if (reset) begin
                check("reset_valid", out_valid == 1'b0, out_valid, 0);
                check("reset_sin", sin_out == 8'h00, s, 0);
                check("reset_cos", cos_out == 8'h00, c, 0);
                check("reset_phase", phase == 32'h0, phase, 0);
                hold_s = 0;
                hold_c = 0;
            end else begin
                check("phase", phase == exp_phase, phase, exp_phase);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 1'b0, 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("latency", cyc == e.due, cyc, e.due);
                        check("sin", (s == e.s0) || (s == e.s1), s, e.s0);
                        check("cos", (c == e.c0) || (c == e.c1), c, e.c0);
                        check("no_neg_full", (sin_out != 8'h80) && (cos_out != 8'h80), {sin_out, cos_out}, 0);
                        $display("sample cyc=%0d sin=%0d cos=%0d exp=(%0d,%0d)", cyc, s, c, e.s0, e.c0);
`ifdef NCO_PHASE_DITHER_EN
                        hold_s = s;
                        hold_c = c;
`else
                        hold_s = e.s0;
                        hold_c = e.c0;
`endif
                    end
                end else begin
                    check("hold_sin", s == hold_s, s, hold_s);
                    check("hold_cos", c == hold_c, c, hold_c);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] offs [4];
        offs[0] = 32'h4000_0000; offs[1] = 32'h8000_0000;
        offs[2] = 32'hC000_0000; offs[3] = 32'h2000_0000;

        // Reset, then a full-circle sweep at step 0x0400_0000.
        repeat (3) step(0, 0, 0, 0, 0, 1);
        step(0, 1, 32'h0400_0000, 0, 0, 0);
        repeat (70) step(1, 0, 0, 0, 0, 0);

        // Fixed phase with quadrant offsets.
        step(0, 1, 32'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, offs[i], 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);

        // Bubble pattern 1,0,0,1 on a moving phase.
        step(0, 1, 32'h0100_0000, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);

        // Word swap during an enabled cycle: old step first, new step after.
        step(1, 1, 32'h0800_0000, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // phase_sync together with enable samples 0x1234_5678 first.
        step(0, 1, 32'h1234_5678, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);

        // Reset with two samples in flight.
        step(1, 0, 0, 32'h1000_0000, 0, 0);
        step(1, 0, 0, 32'h3000_0000, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 127) == 0);
        end
        repeat (6) step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drain", sb.size() == 0, sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
